// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multi-cycle control FSM for the 16-bit datapath. Sequences one instruction
// at a time through FETCH -> DECODE -> EXEC [-> MEM [-> WB]] and drives the
// datapath enables, mux selects and the unified-memory request.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   opcode[7:0]     {instr[15:12], instr[7:4]} from the decoder
//   itype[1:0]      00 rType, 01 iType, 10 pType, 11 jType
//   cond[3:0]       Jcond condition code (instr[11:8])
//   flags[4:0]      {C,L,F,Z,N} from the flag register
//   mem_ready       memory completes the current request this cycle
//   ir_en, pc_en    instruction register / PC load enables
//   pc_src[1:0]     00 PC+1, 01 register target
//   mem_req, mem_we memory request valid / write
//   addr_sel        0 PC, 1 register address
//   reg_we          regfile write
//   wb_sel[1:0]     00 ALU, 01 memory data, 10 PC+1
//   alu_b_sel       0 register B, 1 immediate
//   flags_we        latch ALU flags
//   state[2:0]      current FSM state (debug)
//   retired         completed-instruction counter
module multicycle_ctrl #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      opcode,
  input  logic [1:0]      itype,
  input  logic [3:0]      cond,
  input  logic [4:0]      flags,
  input  logic            mem_ready,
  output logic            ir_en,
  output logic            pc_en,
  output logic [1:0]      pc_src,
  output logic            mem_req,
  output logic            mem_we,
  output logic            addr_sel,
  output logic            reg_we,
  output logic [1:0]      wb_sel,
  output logic            alu_b_sel,
  output logic            flags_we,
  output logic [2:0]      state,
  output logic [PC_W-1:0] retired
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [1:0] T_R = 2'b00;
  localparam logic [1:0] T_I = 2'b01;
  localparam logic [1:0] T_P = 2'b10;
  localparam logic [1:0] T_J = 2'b11;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_CMPU  = 8'h08;
  localparam logic [7:0] OP_CMP   = 8'h0B;
  localparam logic [7:0] OP_LOAD  = 8'h40;
  localparam logic [7:0] OP_STOR  = 8'h44;
  localparam logic [7:0] OP_JALR  = 8'h48;
  localparam logic [7:0] OP_JCOND = 8'h4C;

  logic [2:0]      state_reg, state_next;
  logic [PC_W-1:0] retired_reg;

  logic            ir_en_c, pc_en_c, mem_req_c, mem_we_c, addr_sel_c;
  logic            reg_we_c, alu_b_sel_c, flags_we_c;
  logic [1:0]      pc_src_c, wb_sel_c;
  logic            taken;
  logic            is_nop, is_cmp;

  wire flag_c = flags[4];
  wire flag_l = flags[3];
  wire flag_f = flags[2];
  wire flag_z = flags[1];
  wire flag_n = flags[0];

  always_comb begin
    taken = 1'b0;
    case (cond)
      4'h0: taken = flag_z;
      4'h1: taken = !flag_z;
      4'h2: taken = flag_c;
      4'h3: taken = !flag_c;
      4'h4: taken = flag_l;
      4'h5: taken = !flag_l;
      4'h6: taken = flag_n;
      4'h7: taken = !flag_n;
      4'h8: taken = flag_f;
      4'h9: taken = !flag_f;
      4'hA: taken = !flag_l && !flag_z;
      4'hB: taken = flag_l || flag_z;
      4'hC: taken = !flag_n && !flag_z;
      4'hD: taken = flag_n || flag_z;
      4'hE: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Compares (register and immediate forms) update flags only.
  assign is_nop = (opcode == OP_NOP);
  assign is_cmp = (opcode == OP_CMP) || (opcode == OP_CMPU) ||
                  (opcode[7:4] == 4'b1011) || (opcode[7:4] == 4'b1100);

  always_comb begin
    state_next  = state_reg;
    ir_en_c     = 1'b0;
    pc_en_c     = 1'b0;
    pc_src_c    = 2'b00;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    addr_sel_c  = 1'b0;
    reg_we_c    = 1'b0;
    wb_sel_c    = 2'b00;
    alu_b_sel_c = 1'b0;
    flags_we_c  = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_en_c    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: state_next = S_EXEC;
      S_EXEC: begin
        state_next = S_FETCH;
        pc_en_c    = 1'b1;
        case (itype)
          T_R, T_I: begin
            alu_b_sel_c = (itype == T_I);
            flags_we_c  = !is_nop;
            reg_we_c    = !(is_nop || is_cmp);
          end
          T_P: begin
            // Only LOAD/STOR go to memory; anything else retires as a NOP.
            if (opcode == OP_LOAD || opcode == OP_STOR) begin
              pc_en_c    = 1'b0;
              state_next = S_MEM;
            end
          end
          T_J: begin
            if (opcode == OP_JALR) begin
              reg_we_c = 1'b1;
              wb_sel_c = 2'b10;
              pc_src_c = 2'b01;
            end else if (opcode == OP_JCOND) begin
              pc_src_c = taken ? 2'b01 : 2'b00;
            end
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        mem_we_c   = (opcode == OP_STOR);
        if (mem_ready) begin
          if (opcode == OP_STOR) begin
            pc_en_c    = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we_c   = 1'b1;
        wb_sel_c   = 2'b01;
        pc_en_c    = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      retired_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (pc_en_c)
        retired_reg <= retired_reg + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  // Reset masks every strobe combinationally so a request in flight drops
  // immediately rather than at the next edge.
  assign ir_en     = rst_n & ir_en_c;
  assign pc_en     = rst_n & pc_en_c;
  assign pc_src    = rst_n ? pc_src_c : 2'b00;
  assign mem_req   = rst_n & mem_req_c;
  assign mem_we    = rst_n & mem_we_c;
  assign addr_sel  = rst_n & addr_sel_c;
  assign reg_we    = rst_n & reg_we_c;
  assign wb_sel    = rst_n ? wb_sel_c : 2'b00;
  assign alu_b_sel = rst_n & alu_b_sel_c;
  assign flags_we  = rst_n & flags_we_c;
  assign state     = state_reg;
  assign retired   = retired_reg;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  opcode;
  logic [1:0]  itype;
  logic [3:0]  cond;
  logic [4:0]  flags;
  logic        mem_ready;
  logic        ir_en, pc_en, mem_req, mem_we, addr_sel, reg_we, alu_b_sel, flags_we;
  logic [1:0]  pc_src, wb_sel;
  logic [2:0]  state;
  logic [15:0] retired;

  multicycle_ctrl #(.PC_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .itype(itype), .cond(cond),
    .flags(flags), .mem_ready(mem_ready), .ir_en(ir_en), .pc_en(pc_en),
    .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .alu_b_sel(alu_b_sel), .flags_we(flags_we),
    .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  wire [11:0] outs = {ir_en, pc_en, pc_src, mem_req, mem_we, addr_sel,
                      reg_we, wb_sel, alu_b_sel, flags_we};

  typedef struct {
    string      name;
    logic [7:0] op;
    logic [1:0] ity;
    logic [3:0] cnd;
    logic [4:0] flg;
    logic       e_reg_we;
    logic [1:0] e_wb_sel;
    logic       e_alu_b;
    logic       e_flags_we;
    logic [1:0] e_pc_src;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] exp_ret;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Independent model of the Jcond taken table; flags = {C,L,F,Z,N}.
  function automatic logic model_taken(input logic [3:0] c, input logic [4:0] f);
    logic fc, fl, ff, fz, fn;
    fc = f[4]; fl = f[3]; ff = f[2]; fz = f[1]; fn = f[0];
    case (c)
      4'd0:  return fz;
      4'd1:  return ~fz;
      4'd2:  return fc;
      4'd3:  return ~fc;
      4'd4:  return fl;
      4'd5:  return ~fl;
      4'd6:  return fn;
      4'd7:  return ~fn;
      4'd8:  return ff;
      4'd9:  return ~ff;
      4'd10: return ~fl & ~fz;
      4'd11: return fl | fz;
      4'd12: return ~fn & ~fz;
      4'd13: return fn | fz;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Three-cycle instruction (FETCH, DECODE, EXEC) with zero-wait fetch.
  // Entered in FETCH shortly after a rising edge.
  task automatic run_alu(input vec_t v, input bit quiet);
    opcode = v.op; itype = v.ity; cond = v.cnd; flags = v.flg; mem_ready = 1'b1;
    #1;
    if (!quiet) begin
      chk({v.name, " fetch state"}, state, 0);
      chk({v.name, " fetch ir_en"}, ir_en, 1);
    end
    next_cycle(); #1;
    if (!quiet) begin
      chk({v.name, " decode state"}, state, 1);
      chk({v.name, " decode outs"}, outs, 0);
    end
    next_cycle(); #1;
    if (!quiet) begin
      chk({v.name, " exec state"}, state, 2);
      chk({v.name, " exec reg_we"}, reg_we, v.e_reg_we);
      chk({v.name, " exec wb_sel"}, wb_sel, v.e_wb_sel);
      chk({v.name, " exec alu_b_sel"}, alu_b_sel, v.e_alu_b);
      chk({v.name, " exec flags_we"}, flags_we, v.e_flags_we);
      chk({v.name, " exec pc_en"}, pc_en, 1);
      chk({v.name, " exec mem_req"}, mem_req, 0);
    end
    chk({v.name, " exec pc_src"}, pc_src, v.e_pc_src);
    exp_ret = exp_ret + 16'd1;
    next_cycle(); #1;
    chk({v.name, " next state"}, state, 0);
    chk({v.name, " retired"}, retired, exp_ret);
    $display("[TB] %s op=%h type=%0d cond=%h flags=%b retired=%0d", v.name, v.op, v.ity, v.cnd, v.flg, retired);
  endtask

  vec_t vecs[12];
  vec_t v;
  int   irq_count;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    //           name       op     ity    cnd    flg       rw   wb     b    fw   src
    vecs[0]  = '{"ADD",     8'h05, 2'd0, 4'h0, 5'b00000, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0};
    vecs[1]  = '{"ADDI",    8'h50, 2'd1, 4'h0, 5'b00000, 1'b1, 2'd0, 1'b1, 1'b1, 2'd0};
    vecs[2]  = '{"CMP",     8'h0B, 2'd0, 4'h0, 5'b00000, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0};
    vecs[3]  = '{"CMPU",    8'h08, 2'd0, 4'h0, 5'b00000, 1'b0, 2'd0, 1'b0, 1'b1, 2'd0};
    vecs[4]  = '{"CMPI",    8'hB3, 2'd1, 4'h0, 5'b00000, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0};
    vecs[5]  = '{"CMPUI",   8'hC7, 2'd1, 4'h0, 5'b00000, 1'b0, 2'd0, 1'b1, 1'b1, 2'd0};
    vecs[6]  = '{"NOP",     8'h00, 2'd0, 4'h0, 5'b00000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0};
    vecs[7]  = '{"JALR",    8'h48, 2'd3, 4'h0, 5'b00000, 1'b1, 2'd2, 1'b0, 1'b0, 2'd1};
    vecs[8]  = '{"JEQ_tk",  8'h4C, 2'd3, 4'h0, 5'b00010, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1};
    vecs[9]  = '{"JNEVER",  8'h4C, 2'd3, 4'hF, 5'b11111, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0};
    vecs[10] = '{"ILL_J",   8'h40, 2'd3, 4'h0, 5'b00000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{"ILL_P",   8'h05, 2'd2, 4'h0, 5'b00000, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0};

    rst_n = 1'b0; opcode = 8'h00; itype = 2'd0; cond = 4'h0; flags = 5'd0; mem_ready = 1'b0;
    exp_ret = 16'd0;

    // Reset held for three cycles, then released.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      chk("reset outs", outs, 0);
      chk("reset state", state, 0);
    end
    rst_n = 1'b1; #1;
    chk("post-reset state", state, 0);
    chk("post-reset mem_req", mem_req, 1);
    chk("post-reset retired", retired, 0);
    $display("[TB] reset released state=%0d mem_req=%0d retired=%0d", state, mem_req, retired);

    foreach (vecs[i]) run_alu(vecs[i], 1'b0);

    // LOAD with two wait cycles in MEM: 0,1,2,3,3,3,4.
    opcode = 8'h40; itype = 2'd2; mem_ready = 1'b1; #1;
    chk("load fetch state", state, 0);
    next_cycle(); #1; chk("load decode state", state, 1);
    next_cycle(); #1;
    chk("load exec state", state, 2);
    chk("load exec outs", outs, 0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2); #1;
      chk("load mem state", state, 3);
      chk("load mem req/we/addr", {mem_req, mem_we, addr_sel}, 3'b101);
      chk("load mem pc_en", pc_en, 0);
      next_cycle();
    end
    #1;
    chk("load wb state", state, 4);
    chk("load wb reg_we/wb_sel", {reg_we, wb_sel}, 3'b101);
    chk("load wb pc_en/src", {pc_en, pc_src}, 3'b100);
    exp_ret = exp_ret + 16'd1;
    next_cycle(); #1;
    chk("load next state", state, 0);
    chk("load retired", retired, exp_ret);
    $display("[TB] LOAD wait=2 retired=%0d", retired);

    // STOR, zero-wait: no WB, retire on the ready cycle in MEM.
    opcode = 8'h44; itype = 2'd2; mem_ready = 1'b1; #1;
    next_cycle(); #1; chk("stor decode state", state, 1);
    next_cycle(); #1; chk("stor exec outs", outs, 0);
    next_cycle(); #1;
    chk("stor mem state", state, 3);
    chk("stor mem req/we/addr", {mem_req, mem_we, addr_sel}, 3'b111);
    chk("stor mem pc_en/src", {pc_en, pc_src}, 3'b100);
    chk("stor mem reg_we", reg_we, 0);
    exp_ret = exp_ret + 16'd1;
    next_cycle(); #1;
    chk("stor next state", state, 0);
    chk("stor retired", retired, exp_ret);
    $display("[TB] STOR retired=%0d", retired);

    // Jcond sweep: every condition code against every flag vector.
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 32; f++) begin
        v = '{"JCOND", 8'h4C, 2'd3, 4'(c), 5'(f), 1'b0, 2'd0, 1'b0, 1'b0, 2'd0};
        v.e_pc_src = {1'b0, model_taken(4'(c), 5'(f))};
        run_alu(v, 1'b1);
      end
    end

    // Counter wrap: preload all-ones, then retire one NOP.
    force dut.retired_reg = 16'hFFFF;
    #1;
    release dut.retired_reg;
    #1;
    chk("wrap preload", retired, 16'hFFFF);
    exp_ret = 16'hFFFF;
    run_alu(vecs[6], 1'b0);

    // Ten-cycle fetch stall: ir_en must pulse exactly once.
    opcode = 8'h00; itype = 2'd0; mem_ready = 1'b0; irq_count = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ir_en) irq_count++;
      chk("stall state", state, 0);
      next_cycle();
    end
    mem_ready = 1'b1; #1;
    if (ir_en) irq_count++;
    next_cycle(); #1;
    chk("stall decode state", state, 1);
    if (ir_en) irq_count++;
    chk("stall ir_en count", irq_count, 1);
    next_cycle(); #1; chk("stall exec state", state, 2);
    exp_ret = exp_ret + 16'd1;
    next_cycle(); #1;
    chk("stall next state", state, 0);
    chk("stall retired", retired, exp_ret);
    $display("[TB] fetch stall 10 cycles ir_en pulses=%0d retired=%0d", irq_count, retired);

    // Reset asserted mid memory request: outputs drop before the next edge.
    opcode = 8'h44; itype = 2'd2; mem_ready = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    mem_ready = 1'b0; #1;
    chk("midreset pre state", state, 3);
    chk("midreset pre mem_req", mem_req, 1);
    rst_n = 1'b0; #1;
    chk("midreset outs", outs, 0);
    chk("midreset state", state, 0);
    chk("midreset retired", retired, 0);
    next_cycle(); next_cycle();
    rst_n = 1'b1; mem_ready = 1'b1; #1;
    chk("midreset release mem_req", mem_req, 1);
    $display("[TB] reset during MEM, outputs=%h state=%0d", outs, state);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM that sequences the 16-bit datapath: instruction fetch, decode, ALU execute, memory access and register writeback.
- Consumes the instruction decoder's opcode (instr[15:12] concatenated with instr[7:4]), instruction type and condition field, plus the ALU flag register.
- Drives IR/PC/regfile/flag enables, mux selects and a ready/request handshake to the shared unified memory.
- Sits between the decoder and the datapath; one instruction in flight at a time.

Parameters:
- PC_W, 16, width of PC-related select paths and retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- opcode  in  8  decoder opcode {instr[15:12], instr[7:4]}.
- itype  in  2  decoder type: 00 rType, 01 iType, 10 pType, 11 jType.
- cond  in  4  instr[11:8], Jcond condition code.
- flags  in  5  {C,L,F,Z,N} from the flag register.
- mem_ready  in  1  memory completes current request this cycle.
- ir_en  out  1  load the instruction register.
- pc_en  out  1  update the PC.
- pc_src  out  2  00 PC+1, 01 register target (Rtarget), 10/11 reserved.
- mem_req  out  1  memory request valid.
- mem_we  out  1  memory write (STOR).
- addr_sel  out  1  0 = PC, 1 = register (Raddr).
- reg_we  out  1  regfile write to Rdest.
- wb_sel  out  2  00 ALU result, 01 memory data, 10 PC+1.
- alu_b_sel  out  1  0 = register B, 1 = immediate.
- flags_we  out  1  latch ALU flags.
- state  out  3  current FSM state, for debug.
- retired  out  PC_W  count of completed instructions.

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5-7 are unreachable and recover to FETCH on the next edge.
- Reset (rst_n=0, asynchronous, any state, including mid memory request):
  - state=FETCH, retired=0.
  - All outputs 0 except state.
  - The first request after reset is issued in the first cycle after deassertion.
- Outputs are Moore/Mealy combinational from state, itype, opcode and mem_ready. All enables not listed for a state are 0.
- FETCH:
  - mem_req=1, addr_sel=0.
  - While mem_ready=0: stay in FETCH, ir_en=0.
  - When mem_ready=1: ir_en=1, next state DECODE.
- DECODE: no enables asserted. Next state EXEC after 1 cycle.
- EXEC, rType/iType:
  - alu_b_sel = (itype==01).
  - flags_we=1.
  - reg_we=1, wb_sel=00, except for CMP/CMPU (0000_1011, 0000_1000), CMPI/CMPUI (1011_xxxx, 1100_xxxx) and NOP (0000_0000), which force reg_we=0.
  - NOP also forces flags_we=0.
  - pc_en=1, pc_src=00. Next state FETCH.
- EXEC, pType: no enables asserted. Next state MEM.
- MEM:
  - mem_req=1, addr_sel=1, mem_we = (opcode==0100_0100).
  - Hold in MEM while mem_ready=0.
  - On mem_ready with LOAD: next state WB.
  - On mem_ready with STOR: pc_en=1, pc_src=00, next state FETCH.
- WB: reg_we=1, wb_sel=01, pc_en=1, pc_src=00. Next state FETCH.
- EXEC, jType JALR (0100_1000): reg_we=1, wb_sel=10, pc_en=1, pc_src=01. Next state FETCH.
- EXEC, jType Jcond (0100_1100): pc_en=1, pc_src = taken ? 01 : 00. No regfile or flag write. Next state FETCH.
- Jcond taken condition, by cond code:
  - EQ 0000: Z
  - NE 0001: !Z
  - CS 0010: C
  - CC 0011: !C
  - HI 0100: L
  - LS 0101: !L
  - GT 0110: N
  - LE 0111: !N
  - FS 1000: F
  - FC 1001: !F
  - LO 1010: !L&!Z
  - HS 1011: L|Z
  - LT 1100: !N&!Z
  - GE 1101: N|Z
  - UC 1110: 1
  - never 1111: 0
- Illegal opcode in EXEC (decoder type unknown, or jType/pType with an unlisted opcode): no enables except pc_en=1, pc_src=00. Treated as NOP.
- Retirement:
  - retired increments by 1 on each edge where pc_en=1.
  - It wraps from 2^PC_W-1 to 0.
- Latency at zero-wait memory:
  - ALU/jump: 3 cycles.
  - STOR: 4 cycles.
  - LOAD: 5 cycles.
  - Each mem_ready=0 cycle adds 1.
- mem_ready is ignored outside FETCH and MEM.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release → state=0, mem_req=1, retired=0. Assert rst_n=0 while in MEM with mem_req=1 → all outputs 0 immediately, before the next clock edge.
- ADD (opcode 0000_0101, itype 00), mem_ready tied 1 → states 0,1,2; in EXEC reg_we=1, flags_we=1, alu_b_sel=0, pc_en=1; retired=1.
- CMPI (1011_xxxx, itype 01) → in EXEC reg_we=0, flags_we=1, alu_b_sel=1. Same cycle count as ADD.
- LOAD with mem_ready low for 2 cycles in MEM → state sequence 0,1,2,3,3,3,4; in WB reg_we=1, wb_sel=01. STOR → mem_we=1 in MEM, no WB state, pc_en on the ready cycle.
- Jcond: sweep all 16 cond codes × 32 flag vectors, checking pc_src against the taken table (e.g. cond=0000, Z=1 → 01; cond=1111 → 00). JALR → reg_we=1, wb_sel=10, pc_src=01.
- Counter wrap: preload via 65535 NOPs, or force retired=16'hFFFF → next retire gives 0. Fetch stall of 10 cycles → ir_en asserted exactly once.
